// File: rtl/partitioned_ram_if.sv
// Request, clear and limit-programming signals of the partitioned data RAM.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the master holds its request stable until then,
// and req_ready may depend combinationally on clear_start.
interface partitioned_ram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int PART_BITS  = 2
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [DATA_WIDTH/8-1:0]   byte_enable;
   logic [PART_BITS-1:0]      partition;
   logic [ADDR_WIDTH-1:0]     address;
   logic [DATA_WIDTH-1:0]     write_data;
   logic                      read_valid;
   logic [DATA_WIDTH-1:0]     read_data;
   logic                      fault;
   logic                      clear_start;
   logic                      busy;
   logic                      limit_write;
   logic [ADDR_WIDTH:0]       limit_value;

   modport master (
      output req_valid, req_write, byte_enable, partition, address, write_data,
             clear_start, limit_write, limit_value,
      input  req_ready, read_valid, read_data, fault, busy
   );

   modport slave (
      input  req_valid, req_write, byte_enable, partition, address, write_data,
             clear_start, limit_write, limit_value,
      output req_ready, read_valid, read_data, fault, busy
   );
endinterface

// File: rtl/partitioned_ram.sv
// Partitioned synchronous-read data memory with per-partition limit
// registers, byte-lane writes and a hardware partition clear engine.
module partitioned_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int PART_BITS  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   partitioned_ram_if.slave bus,
   output logic [0:0] dbg_state
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int PARTS = 2 ** PART_BITS;
   localparam int DEPTH = 2 ** (PART_BITS + ADDR_WIDTH);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   // Full-partition limit and the last word index, both in counter width.
   localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

   logic [DATA_WIDTH-1:0]          mem [DEPTH];
   logic [ADDR_WIDTH:0]            limit [PARTS];
   logic [0:0]                     state;
   logic [ADDR_WIDTH:0]            clr_cnt;
   logic [PART_BITS-1:0]           clr_part;

   logic                           accept;
   logic                           over;
   logic                           wr_en;
   logic [ADDR_WIDTH:0]            limit_in;
   logic [PART_BITS+ADDR_WIDTH-1:0] phys;
   logic [PART_BITS+ADDR_WIDTH-1:0] clr_phys;

   assign bus.req_ready = (state == IDLE) && !bus.clear_start;
   assign bus.busy      = (state == CLEAR);
   assign dbg_state     = state;

   assign accept   = bus.req_valid && bus.req_ready;
   // Checked against the limit as it stands before any same-edge update.
   assign over     = {1'b0, bus.address} >= limit[bus.partition];
   assign wr_en    = accept && bus.req_write && !over;
   assign phys     = {bus.partition, bus.address};
   assign clr_phys = {clr_part, clr_cnt[ADDR_WIDTH-1:0]};
   assign limit_in = (bus.limit_value > FULL) ? FULL : bus.limit_value;

   // Control FSM: IDLE serves requests, CLEAR sweeps one partition to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         clr_cnt  <= '0;
         clr_part <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.clear_start) begin
                  state    <= CLEAR;
                  clr_part <= bus.partition;
                  clr_cnt  <= '0;
               end
            end
            CLEAR: begin
               if (clr_cnt == LAST) begin
                  state   <= IDLE;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Limit registers: clamped load, honoured in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < PARTS; p++) limit[p] <= FULL;
      end else if (bus.limit_write) begin
         limit[bus.partition] <= limit_in;
      end
   end

   // Storage array: clear engine writes zeros, otherwise byte-lane writes.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_phys] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.byte_enable[i]) mem[phys][8*i +: 8] <= bus.write_data[8*i +: 8];
         end
      end
   end

   // Registered read result and one-cycle fault/valid pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.read_valid <= 1'b0;
         bus.fault      <= 1'b0;
         bus.read_data  <= '0;
      end else begin
         bus.read_valid <= accept && !bus.req_write;
         bus.fault      <= accept && over;
         if (accept && !bus.req_write) begin
            bus.read_data <= over ? '0 : mem[phys];
         end
      end
   end
endmodule

// File: tb/tb_partitioned_ram.sv
// Directed bench for partitioned_ram with a queue-based response scoreboard.
module tb_partitioned_ram;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int PB = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [0:0] dbg_state;

   int checks = 0;
   int errors = 0;

   // Expected response entries: {is_read, fault, read_data}.
   logic [DW+1:0] exp_q[$];

   partitioned_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PART_BITS(PB)) ifc ();

   partitioned_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PART_BITS(PB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (ifc),
      .dbg_state (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output pulse pops one expected entry.
   always @(negedge clk) begin
      if (rst_n && (ifc.read_valid !== 1'b0 || ifc.fault !== 1'b0)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_response: rv=%b fault=%b data=%h, none expected",
                     ifc.read_valid, ifc.fault, ifc.read_data);
         end else begin
            logic [DW+1:0] e;
            e = exp_q.pop_front();
            if (ifc.read_valid !== e[DW+1] || ifc.fault !== e[DW] ||
                (e[DW+1] && ifc.read_data !== e[DW-1:0])) begin
               errors++;
               $display("FAIL response: got rv=%b fault=%b data=%h expected rv=%b fault=%b data=%h",
                        ifc.read_valid, ifc.fault, ifc.read_data, e[DW+1], e[DW], e[DW-1:0]);
            end
         end
      end
   end

   // Driver: called at a negedge, returns at the negedge after acceptance.
   task automatic access(input logic wr, input logic [PB-1:0] p, input logic [AW-1:0] a,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] d,
                         input logic ef, input logic [DW-1:0] ed);
      int n;
      ifc.req_valid   = 1'b1;
      ifc.req_write   = wr;
      ifc.partition   = p;
      ifc.address     = a;
      ifc.byte_enable = be;
      ifc.write_data  = d;
      if (!wr || ef) exp_q.push_back({!wr, ef, ed});
      n = 0;
      #1;
      while (!ifc.req_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!ifc.req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", ifc.req_ready, n);
      end
      @(posedge clk);
      @(negedge clk);
      ifc.req_valid = 1'b0;
   endtask

   task automatic set_limit(input logic [PB-1:0] p, input logic [AW:0] v);
      ifc.limit_write = 1'b1;
      ifc.partition   = p;
      ifc.limit_value = v;
      @(posedge clk);
      @(negedge clk);
      ifc.limit_write = 1'b0;
   endtask

   task automatic start_clear(input logic [PB-1:0] p);
      ifc.clear_start = 1'b1;
      ifc.partition   = p;
      @(posedge clk);
      @(negedge clk);
      ifc.clear_start = 1'b0;
   endtask

   initial begin
      int n;
      int ready_bad;
      ifc.req_valid   = 1'b0;
      ifc.req_write   = 1'b0;
      ifc.byte_enable = '0;
      ifc.partition   = '0;
      ifc.address     = '0;
      ifc.write_data  = '0;
      ifc.clear_start = 1'b0;
      ifc.limit_write = 1'b0;
      ifc.limit_value = '0;

      // Reset.
      repeat (3) @(negedge clk);
      check("reset_read_valid", {31'd0, ifc.read_valid}, 32'd0);
      check("reset_fault", {31'd0, ifc.fault}, 32'd0);
      check("reset_read_data", ifc.read_data, 32'd0);
      check("reset_busy", {31'd0, ifc.busy}, 32'd0);
      check("reset_state", {31'd0, dbg_state}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("reset_ready", {31'd0, ifc.req_ready}, 32'd1);
      @(negedge clk);

      // Basic write then read.
      access(1'b1, 2'd1, 10'h005, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
      access(1'b0, 2'd1, 10'h005, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF);

      // Byte-lane merge.
      access(1'b1, 2'd0, 10'h010, 4'hF, 32'h11223344, 1'b0, 32'h0);
      access(1'b1, 2'd0, 10'h010, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0);
      access(1'b0, 2'd0, 10'h010, 4'hF, 32'h0, 1'b0, 32'h11BB33DD);

      // Limit boundary on P2.
      access(1'b1, 2'd2, 10'h0FF, 4'hF, 32'h0F0F0F0F, 1'b0, 32'h0);
      access(1'b1, 2'd2, 10'h100, 4'hF, 32'h55AA55AA, 1'b0, 32'h0);
      set_limit(2'd2, 11'h100);
      access(1'b0, 2'd2, 10'h0FF, 4'h0, 32'h0, 1'b0, 32'h0F0F0F0F);
      access(1'b0, 2'd2, 10'h100, 4'h0, 32'h0, 1'b1, 32'h0);
      access(1'b1, 2'd2, 10'h100, 4'hF, 32'h12345678, 1'b1, 32'h0);
      set_limit(2'd2, 11'h200);
      access(1'b0, 2'd2, 10'h100, 4'h0, 32'h0, 1'b0, 32'h55AA55AA);
      set_limit(2'd2, 11'h100);

      // Fill P3 with nonzero data.
      for (int a = 0; a < 1024; a++) begin
         access(1'b1, 2'd3, a[AW-1:0], 4'hF, 32'hA5000000 | a, 1'b0, 32'h0);
      end
      access(1'b0, 2'd3, 10'h155, 4'h0, 32'h0, 1'b0, 32'hA5000155);

      // Clear P3 with a simultaneous pending read.
      ifc.clear_start = 1'b1;
      ifc.partition   = 2'd3;
      ifc.req_valid   = 1'b1;
      ifc.req_write   = 1'b0;
      ifc.address     = 10'h000;
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      #1;
      check("clear_start_blocks_ready", {31'd0, ifc.req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      ifc.clear_start = 1'b0;
      check("busy_rises", {31'd0, ifc.busy}, 32'd1);
      check("clear_state", {31'd0, dbg_state}, 32'd1);
      n = 0;
      ready_bad = 0;
      while (ifc.busy && n < 2000) begin
         if (ifc.req_ready) ready_bad++;
         @(negedge clk);
         n++;
      end
      check("busy_cycles", n, 32'd1024);
      check("ready_low_in_clear", ready_bad, 32'd0);
      check("ready_after_clear", {31'd0, ifc.req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      ifc.req_valid = 1'b0;
      access(1'b0, 2'd3, 10'h001, 4'h0, 32'h0, 1'b0, 32'h0);
      access(1'b0, 2'd3, 10'h155, 4'h0, 32'h0, 1'b0, 32'h0);
      access(1'b0, 2'd3, 10'h3FF, 4'h0, 32'h0, 1'b0, 32'h0);
      access(1'b0, 2'd1, 10'h005, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF);
      access(1'b0, 2'd0, 10'h010, 4'h0, 32'h0, 1'b0, 32'h11BB33DD);
      access(1'b0, 2'd2, 10'h0FF, 4'h0, 32'h0, 1'b0, 32'h0F0F0F0F);

      // Reset part-way through a clear.
      access(1'b0, 2'd3, 10'h000, 4'h0, 32'h0, 1'b0, 32'h0);
      start_clear(2'd3);
      repeat (300) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midclear_reset_busy", {31'd0, ifc.busy}, 32'd0);
      check("midclear_reset_read_valid", {31'd0, ifc.read_valid}, 32'd0);
      check("midclear_reset_state", {31'd0, dbg_state}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", {31'd0, ifc.req_ready}, 32'd1);
      @(negedge clk);
      // P2 limit was 0x100 before reset; the full limit must be back.
      access(1'b1, 2'd2, 10'h3FF, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
      access(1'b0, 2'd2, 10'h3FF, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D);

      // Clamp and zero limits.
      set_limit(2'd0, 11'h7FF);
      access(1'b1, 2'd0, 10'h3FF, 4'hF, 32'h600DF00D, 1'b0, 32'h0);
      access(1'b0, 2'd0, 10'h3FF, 4'h0, 32'h0, 1'b0, 32'h600DF00D);
      set_limit(2'd1, 11'h000);
      access(1'b0, 2'd1, 10'h000, 4'h0, 32'h0, 1'b1, 32'h0);
      access(1'b1, 2'd1, 10'h005, 4'hF, 32'h0BADC0DE, 1'b1, 32'h0);
      set_limit(2'd1, 11'h400);
      access(1'b0, 2'd1, 10'h005, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF);

      // Drain and report.
      repeat (5) @(negedge clk);
      check("responses_outstanding", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/partitioned_ram.md
# partitioned_ram

Single-clock, synchronous-read data memory for the processor, split into 2**PART_BITS equal process partitions. Each partition has a programmable limit register, and out-of-limit accesses fault instead of touching memory. Requests use a valid/ready handshake, writes take per-byte enables, and a hardware clear engine zeroes a whole partition. The block sits between the processor's memory stage and the OS support logic, which programs limits and clears partitions on process create and destroy.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10: word-address width within one partition; partition size is 2**ADDR_WIDTH words.
- PART_BITS, 2: partition-select width; total storage is 2**(PART_BITS+ADDR_WIDTH) words.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req_Valid  in  1  access request present.
- Req_Ready  out  1  block can accept a request this cycle.
- Req_Write  in  1  1 = write, 0 = read.
- Byte_Enable  in  DATA_WIDTH/8  per-byte write lanes; ignored on reads.
- Partition  in  PART_BITS  partition for the request, clear or limit write.
- Address  in  ADDR_WIDTH  word address within the partition.
- Write_Data  in  DATA_WIDTH  write data.
- Read_Valid  out  1  Read_Data valid this cycle.
- Read_Data  out  DATA_WIDTH  registered read result.
- Fault  out  1  one-cycle pulse: the access exceeded the partition limit.
- Clear_Start  in  1  start zeroing the partition on Partition.
- Busy  out  1  clear engine running.
- Limit_Write  in  1  load the limit register of Partition.
- Limit_Value  in  ADDR_WIDTH+1  new limit, in words.

## Operation
- Physical address = {Partition, Address}.
- States are IDLE and CLEAR.
- Req_Ready = (state == IDLE) && !Clear_Start, combinational.
- A request is accepted on a rising edge with Req_Valid && Req_Ready.
- Limit check: an accepted access with Address >= Limit[Partition] is a fault.
  - A faulting access causes no memory write.
  - A faulting read returns Read_Data = 0.
- Write, not faulting: lane i (bits 8i+7:8i) is written only when Byte_Enable[i] = 1; other lanes keep their value.
- Read: returns the full word; Byte_Enable has no effect.
- IDLE -> CLEAR when Clear_Start = 1 in IDLE.
  - The partition and clear counter (ADDR_WIDTH+1 bits) are latched; the counter starts at 0.
  - Clear_Start wins over a simultaneous Req_Valid; that request is not accepted and stays pending.
- In CLEAR, the engine writes zero to {latched partition, counter} each cycle.
  - Busy = 1; Req_Ready = 0.
  - Clear_Start is ignored.
  - The clear ignores the limit and covers all 2**ADDR_WIDTH words.
- CLEAR -> IDLE after the write to address 2**ADDR_WIDTH-1.
- Limit registers:
  - Reset value is 2**ADDR_WIDTH (full partition).
  - Limit_Write is honoured in any state and takes effect from the next edge.
  - A Limit_Value above 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH.
  - A limit of 0 makes every access to that partition fault.
- An accepted access and a Limit_Write to the same partition in the same cycle: the access is checked against the old limit.
- Reset asserted at any time:
  - state = IDLE, clear counter = 0, all limits = 2**ADDR_WIDTH.
  - Read_Valid = 0, Read_Data = 0, Fault = 0, Busy = 0.
  - Memory contents are not reset; a partition left half-cleared stays partially cleared.

## Timing
- Read latency is 1 cycle. Read_Valid and Read_Data (or Fault) are registered and appear the cycle after acceptance.
- Read_Valid is high for exactly one cycle per accepted read.
- Read_Data holds its last value when Read_Valid = 0.
- A write is committed at the accepting edge.
- Back-to-back accesses:
  - A read accepted the next cycle at the same address returns the new data.
  - One access is accepted per cycle; full throughput is sustained.
- Fault on a faulting read: pulses together with Read_Valid.
- Fault on a faulting write: pulses alone, with Read_Valid = 0, the cycle after acceptance.
- Clear timing:
  - Busy rises the cycle after Clear_Start is sampled.
  - Busy stays high for exactly 2**ADDR_WIDTH cycles.
  - Req_Ready can return high the cycle after Busy falls.
- Reset mid-clear: Busy drops asynchronously; Req_Ready = 1 on the first edge after release (if Clear_Start = 0).

## Test plan
- Reset, then write 0xDEADBEEF to P1:0x005 with Byte_Enable 1111, then read it -> Read_Valid one cycle later with 0xDEADBEEF, Fault = 0.
- Write 0x11223344 to P0:0x010 with BE 1111, then write 0xAABBCCDD to P0:0x010 with BE 0101, then read -> 0x11BB33DD.
- Limit_Write P2 = 0x100, then read P2:0x0FF and P2:0x100 back-to-back -> first Read_Valid with Fault = 0; second Read_Valid with Fault = 1 and Read_Data 0. A write to P2:0x100 leaves memory unchanged and pulses Fault only.
- Fill P3 with nonzero data, then Clear_Start with Req_Valid also high -> request not accepted. Busy is high for 1024 cycles and Req_Ready = 0 throughout. Afterwards the pending request is accepted and all P3 reads return 0, while P0–P2 data is untouched.
- Assert Reset 300 cycles into a clear -> Busy = 0 and Read_Valid = 0 immediately. After release, Req_Ready = 1 and the limits read back full (access at 0x3FF does not fault).
- Limit_Value 0x7FF to P0 -> clamped; access at 0x3FF does not fault. Limit 0 on P1 -> access at 0x000 faults.
